// File: rtl/image_blend_pipe_if.sv
// Stream bundle for image_blend_pipe: one input beat carries a pixel from
// each of two source images, and one output beat carries the blended pixel.
// The DUT side is "slave" (it consumes s_* and produces m_*); the producer
// and consumer side is "master".
interface image_blend_pipe_if #(
   parameter int DATA_W = 8,
   parameter int CH     = 3
) ();

   logic                 s_valid;
   logic                 s_ready;
   logic [CH*DATA_W-1:0] s_pix_a;
   logic [CH*DATA_W-1:0] s_pix_b;
   logic                 m_valid;
   logic                 m_ready;
   logic [CH*DATA_W-1:0] m_pix;
   logic                 m_last;

   modport slave (
      input  s_valid, s_pix_a, s_pix_b, m_ready,
      output s_ready, m_valid, m_pix, m_last
   );

   modport master (
      output s_valid, s_pix_a, s_pix_b, m_ready,
      input  s_ready, m_valid, m_pix, m_last
   );

endinterface

// File: rtl/image_blend_pipe.sv
// image_blend_pipe: two-stage streaming blender.
// Each channel computes out = trunc(a*wa) + trunc(b*wb), where trunc keeps
// the upper DATA_W bits of the 2*DATA_W product. The channel sum either
// wraps or saturates depending on the per-frame sat mode. Weights are
// latched per frame: a cfg_load updates the pending set, and the pending
// set is copied to the active set on the first accepted beat of a frame.

// Approximate 8x8 multiplier core: partial-product bits in the four
// least significant columns are dropped. Those columns only influence
// the low byte of the product, which the blender discards anyway, apart
// from a possible carry into the upper byte.
module multiplier2 (
   input  logic [7:0]  a,
   input  logic [7:0]  b,
   output logic [15:0] p
);

   // Sum the kept partial-product bits column by column.
   always_comb begin
      p = '0;
      for (int i = 0; i < 8; i++) begin
         for (int j = 0; j < 8; j++) begin
            if ((a[i] & b[j]) && ((i + j) >= 4)) begin
               p = p + (16'd1 << (i + j));
            end
         end
      end
   end

endmodule

module image_blend_pipe #(
   parameter int DATA_W    = 8,
   parameter int CH        = 3,
   parameter int FRAME_PIX = 270000,
   parameter int APPROX    = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cfg_load,
   input  logic [DATA_W-1:0] cfg_wa,
   input  logic [DATA_W-1:0] cfg_wb,
   input  logic              cfg_sat,
   image_blend_pipe_if.slave strm,
   output logic              sat_flag,
   output logic [15:0]       frame_cnt
);

   localparam int PW    = 2 * DATA_W;
   localparam int CNT_W = (FRAME_PIX > 1) ? $clog2(FRAME_PIX) : 1;
   localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(FRAME_PIX - 1);
   localparam logic [DATA_W-1:0] W_RESET  = DATA_W'(1) << (DATA_W - 1);

   logic              stall;
   logic              accept;
   logic              frame_start;

   logic [DATA_W-1:0] pend_wa;
   logic [DATA_W-1:0] pend_wb;
   logic              pend_sat;
   logic [DATA_W-1:0] act_wa;
   logic [DATA_W-1:0] act_wb;
   logic              act_sat;
   logic [DATA_W-1:0] eff_wa;
   logic [DATA_W-1:0] eff_wb;
   logic              eff_sat;

   logic [CNT_W-1:0]  pix_cnt;

   logic [PW-1:0]     prod_a [CH];
   logic [PW-1:0]     prod_b [CH];

   logic              s1_valid;
   logic [PW-1:0]     s1_pa [CH];
   logic [PW-1:0]     s1_pb [CH];
   logic              s1_last;
   logic              s1_sat;

   logic [DATA_W:0]       ch_sum [CH];
   logic [CH*DATA_W-1:0]  blend_pix;
   logic                  sat_hit;

   // A held output blocks the whole pipe; the input side sees that directly.
   assign stall        = strm.m_valid && !strm.m_ready;
   assign strm.s_ready = !stall;
   assign accept       = strm.s_valid && !stall;
   assign frame_start  = (pix_cnt == '0);

   // The first beat of a frame already uses the values being copied in,
   // so it reads the pending set; the rest of the frame reads the active set.
   always_comb begin
      eff_wa  = act_wa;
      eff_wb  = act_wb;
      eff_sat = act_sat;
      if (frame_start) begin
         eff_wa  = pend_wa;
         eff_wb  = pend_wb;
         eff_sat = pend_sat;
      end
   end

   // Pending configuration captured on the cfg_load pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_wa  <= W_RESET;
         pend_wb  <= W_RESET;
         pend_sat <= 1'b0;
      end else if (cfg_load) begin
         pend_wa  <= cfg_wa;
         pend_wb  <= cfg_wb;
         pend_sat <= cfg_sat;
      end
   end

   // Active configuration follows pending only at a frame boundary; a
   // same-cycle cfg_load is not visible here yet and lands next frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         act_wa  <= W_RESET;
         act_wb  <= W_RESET;
         act_sat <= 1'b0;
      end else if (accept && frame_start) begin
         act_wa  <= pend_wa;
         act_wb  <= pend_wb;
         act_sat <= pend_sat;
      end
   end

   // Position of the next accepted beat within its frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pix_cnt <= '0;
      end else if (accept) begin
         if (pix_cnt == LAST_IDX) begin
            pix_cnt <= '0;
         end else begin
            pix_cnt <= pix_cnt + CNT_W'(1);
         end
      end
   end

   // Per-channel multipliers and the stage-2 truncated sum.
   for (genvar c = 0; c < CH; c++) begin : g_ch
      logic [DATA_W-1:0] ch_a;
      logic [DATA_W-1:0] ch_b;
      logic              unused_lo;

      assign ch_a = strm.s_pix_a[c*DATA_W +: DATA_W];
      assign ch_b = strm.s_pix_b[c*DATA_W +: DATA_W];

      if ((APPROX != 0) && (DATA_W == 8)) begin : g_approx
         multiplier2 u_mul_a (.a(ch_a), .b(eff_wa), .p(prod_a[c]));
         multiplier2 u_mul_b (.a(ch_b), .b(eff_wb), .p(prod_b[c]));
      end else begin : g_exact
         // APPROX with a non-8-bit width falls back to the exact product.
         assign prod_a[c] = PW'(ch_a) * PW'(eff_wa);
         assign prod_b[c] = PW'(ch_b) * PW'(eff_wb);
      end

      assign ch_sum[c] = {1'b0, s1_pa[c][PW-1:DATA_W]} + {1'b0, s1_pb[c][PW-1:DATA_W]};

      // Low product halves are kept in stage 1 but never reach the output.
      assign unused_lo = ^{s1_pa[c][DATA_W-1:0], s1_pb[c][DATA_W-1:0]};
   end

   // Stage 1: register products, frame-end tag and sat mode on accept.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_last  <= 1'b0;
         s1_sat   <= 1'b0;
         for (int c = 0; c < CH; c++) begin
            s1_pa[c] <= '0;
            s1_pb[c] <= '0;
         end
      end else if (!stall) begin
         s1_valid <= strm.s_valid;
         if (accept) begin
            s1_pa   <= prod_a;
            s1_pb   <= prod_b;
            s1_last <= (pix_cnt == LAST_IDX);
            s1_sat  <= eff_sat;
         end
      end
   end

   // Carry out of a channel sum either clamps to all ones or wraps.
   always_comb begin
      blend_pix = '0;
      sat_hit   = 1'b0;
      for (int c = 0; c < CH; c++) begin
         if (ch_sum[c][DATA_W] && s1_sat) begin
            blend_pix[c*DATA_W +: DATA_W] = '1;
            sat_hit = 1'b1;
         end else begin
            blend_pix[c*DATA_W +: DATA_W] = ch_sum[c][DATA_W-1:0];
         end
      end
   end

   // Stage 2: output register, frozen while the consumer holds off.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         strm.m_valid <= 1'b0;
         strm.m_pix   <= '0;
         strm.m_last  <= 1'b0;
      end else if (!stall) begin
         strm.m_valid <= s1_valid;
         if (s1_valid) begin
            strm.m_pix  <= blend_pix;
            strm.m_last <= s1_last;
         end
      end
   end

   // Sticky saturation indicator, raised as a saturated beat moves to output.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sat_flag <= 1'b0;
      end else if (!stall && s1_valid && sat_hit) begin
         sat_flag <= 1'b1;
      end
   end

   // Count frames whose last pixel has been handed downstream.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_cnt <= '0;
      end else if (strm.m_valid && strm.m_ready && strm.m_last) begin
         frame_cnt <= frame_cnt + 16'd1;
      end
   end

endmodule
